// File: rtl/emisor_instrucciones.sv
// emisor_instrucciones: packs host fields into a program buffer and
// issues the stored program to the ISA datapath over valid/ready.
module emisor_instrucciones #(
  parameter int PROG_DEPTH = 32,
  parameter int ADDR_W     = 5,
  parameter int INSTR_W    = 21
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               carga,
  input  logic [4:0]         dl1,
  input  logic [4:0]         dl2,
  input  logic               we_br,
  input  logic [2:0]         alu_op,
  input  logic [4:0]         dir_ram,
  input  logic               we_ram,
  input  logic               borrar,
  input  logic               iniciar,
  input  logic               detener,
  input  logic               listo_isa,
  output logic [INSTR_W-1:0] instruccion,
  output logic               valida,
  output logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W:0]    cuenta,
  output logic               lleno,
  output logic               desborde,
  output logic               ocupado,
  output logic               terminado
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  typedef struct packed {
    logic       rsv;
    logic [4:0] dl1;
    logic [4:0] dl2;
    logic       we_br;
    logic [2:0] alu_op;
    logic [4:0] dir_ram;
    logic       we_ram;
  } instr_t;

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(PROG_DEPTH);
  localparam logic [ADDR_W:0]   ONE_C   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);

  state_t             state;
  instr_t             word;
  logic [INSTR_W-1:0] mem [PROG_DEPTH];
  logic [ADDR_W-1:0]  pc_nxt;
  logic [ADDR_W-1:0]  wr_idx;
  logic               do_clr;
  logic               do_go;
  logic               do_ld;
  logic               mem_we;
  logic               xfer;
  logic               last;
  logic               vacio;

  assign word.rsv     = 1'b0;
  assign word.dl1     = dl1;
  assign word.dl2     = dl2;
  assign word.we_br   = we_br;
  assign word.alu_op  = alu_op;
  assign word.dir_ram = dir_ram;
  assign word.we_ram  = we_ram;

  // borrar > iniciar > carga, made mutually exclusive up front
  assign do_clr = borrar;
  assign do_go  = iniciar & ~borrar;
  assign do_ld  = carga & ~borrar & ~iniciar;

  assign lleno  = (cuenta == DEPTH_C);
  assign vacio  = (cuenta == '0);
  assign wr_idx = cuenta[ADDR_W-1:0];
  assign mem_we = (state == IDLE) & do_ld & ~lleno;
  assign pc_nxt = pc + PC_ONE;
  assign xfer   = valida & listo_isa;
  assign last   = ({1'b0, pc} == (cuenta - ONE_C));

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_idx] <= INSTR_W'(word);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      instruccion <= '0;
      valida      <= 1'b0;
      pc          <= '0;
      cuenta      <= '0;
      desborde    <= 1'b0;
      ocupado     <= 1'b0;
      terminado   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            do_clr: begin
              cuenta   <= '0;
              desborde <= 1'b0;
            end
            do_go: begin
              if (!vacio) begin
                state       <= RUN;
                pc          <= '0;
                instruccion <= mem[0];
                valida      <= 1'b1;
                ocupado     <= 1'b1;
              end
            end
            do_ld: begin
              if (lleno) begin
                desborde <= 1'b1;
              end else begin
                cuenta <= cuenta + ONE_C;
              end
            end
            default: ;
          endcase
        end
        RUN: begin
          // abort wins even when a transfer lands on the same edge
          if (detener) begin
            state   <= IDLE;
            valida  <= 1'b0;
            pc      <= '0;
            ocupado <= 1'b0;
          end else if (xfer) begin
            if (last) begin
              state     <= FIN;
              valida    <= 1'b0;
              ocupado   <= 1'b0;
              terminado <= 1'b1;
            end else begin
              pc          <= pc_nxt;
              instruccion <= mem[pc_nxt];
            end
          end
        end
        FIN: begin
          terminado <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state   <= IDLE;
          valida  <= 1'b0;
          ocupado <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_emisor_instrucciones.sv
// Bench for emisor_instrucciones: queue-based program model checked
// every cycle, plus directed literal checks per scenario.
module tb_emisor_instrucciones;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        carga = 1'b0;
  logic [4:0]  dl1 = '0;
  logic [4:0]  dl2 = '0;
  logic        we_br = 1'b0;
  logic [2:0]  alu_op = '0;
  logic [4:0]  dir_ram = '0;
  logic        we_ram = 1'b0;
  logic        borrar = 1'b0;
  logic        iniciar = 1'b0;
  logic        detener = 1'b0;
  logic        listo_isa = 1'b0;
  logic [20:0] instruccion;
  logic        valida;
  logic [4:0]  pc;
  logic [5:0]  cuenta;
  logic        lleno;
  logic        desborde;
  logic        ocupado;
  logic        terminado;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  emisor_instrucciones dut (
    .clk(clk), .rst_n(rst_n), .carga(carga),
    .dl1(dl1), .dl2(dl2), .we_br(we_br),
    .alu_op(alu_op), .dir_ram(dir_ram), .we_ram(we_ram),
    .borrar(borrar), .iniciar(iniciar), .detener(detener),
    .listo_isa(listo_isa), .instruccion(instruccion),
    .valida(valida), .pc(pc), .cuenta(cuenta), .lleno(lleno),
    .desborde(desborde), .ocupado(ocupado), .terminado(terminado)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // model: program is a queue, a run is an index walking it
  logic [20:0] m_prog[$];
  bit m_ovf, m_run, m_term;
  int m_pc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_prog.delete();
      m_ovf = 0; m_run = 0; m_term = 0; m_pc = 0;
    end else if (m_run) begin
      if (detener) begin
        m_run = 0; m_pc = 0;
      end else if (listo_isa) begin
        if (m_pc == m_prog.size() - 1) begin
          m_run = 0; m_term = 1;
        end else begin
          m_pc++;
        end
      end
    end else if (m_term) begin
      m_term = 0;
    end else if (borrar) begin
      m_prog.delete(); m_ovf = 0;
    end else if (iniciar) begin
      if (m_prog.size() > 0) begin
        m_run = 1; m_pc = 0;
      end
    end else if (carga) begin
      if (m_prog.size() < 32)
        m_prog.push_back({1'b0, dl1, dl2, we_br, alu_op, dir_ram, we_ram});
      else
        m_ovf = 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_valida", valida, m_run);
      chk("m_ocupado", ocupado, m_run);
      chk("m_terminado", terminado, m_term);
      chk("m_cuenta", cuenta, m_prog.size());
      chk("m_lleno", lleno, m_prog.size() == 32);
      chk("m_desborde", desborde, m_ovf);
      if (m_run) begin
        chk("m_instr", instruccion, m_prog[m_pc]);
        chk("m_pc", pc, m_pc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [20:0] w);
    dl1 = w[19:15]; dl2 = w[14:10]; we_br = w[9];
    alu_op = w[8:6]; dir_ram = w[5:1]; we_ram = w[0];
    carga = 1'b1;
    tick();
    carga = 1'b0;
  endtask

  task automatic pulse_borrar();
    borrar = 1'b1;
    tick();
    borrar = 1'b0;
  endtask

  task automatic start();
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
  endtask

  logic [20:0] wv [4];

  initial begin
    wv[0] = 21'h12345; wv[1] = 21'hFEDCB;
    wv[2] = 21'h55AA1; wv[3] = 21'hABCDE;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valida", valida, 0);
    chk("rst_cuenta", cuenta, 0);
    chk("rst_instr", instruccion, 0);
    chk("rst_ocupado", ocupado, 0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // single entry run
    dl1 = 5'd1; dl2 = 5'd2; we_br = 1'b1;
    alu_op = 3'b010; dir_ram = 5'd4; we_ram = 1'b1;
    carga = 1'b1;
    tick();
    carga = 1'b0;
    chk("t1_cuenta", cuenta, 1);
    listo_isa = 1'b1;
    start();
    chk("t1_valida", valida, 1);
    chk("t1_instr", instruccion, 21'h08A89);
    chk("t1_pc", pc, 0);
    tick();
    chk("t1_valida_off", valida, 0);
    chk("t1_term", terminado, 1);
    tick();
    chk("t1_term_off", terminado, 0);
    chk("t1_ocupado", ocupado, 0);

    // three words back to back
    pulse_borrar();
    for (int i = 0; i < 3; i++) load_word(wv[i]);
    start();
    for (int i = 0; i < 3; i++) begin
      chk("t2_valida", valida, 1);
      chk("t2_ocupado", ocupado, 1);
      chk("t2_pc", pc, i);
      chk("t2_instr", instruccion, wv[i]);
      tick();
    end
    chk("t2_valida_off", valida, 0);
    chk("t2_term", terminado, 1);
    tick();

    // backpressure
    pulse_borrar();
    for (int i = 0; i < 3; i++) load_word(wv[i+1]);
    listo_isa = 1'b0;
    start();
    for (int i = 0; i < 4; i++) begin
      chk("t3_hold_valida", valida, 1);
      chk("t3_hold_pc", pc, 0);
      chk("t3_hold_instr", instruccion, wv[1]);
      if (i < 3) tick();
    end
    listo_isa = 1'b1;
    for (int i = 1; i < 3; i++) begin
      tick();
      chk("t3_pc", pc, i);
      chk("t3_instr", instruccion, wv[i+1]);
    end
    tick();
    chk("t3_term", terminado, 1);
    tick();

    // overflow
    pulse_borrar();
    for (int i = 0; i < 32; i++) load_word(21'(i * 3));
    chk("t4_cuenta", cuenta, 32);
    chk("t4_lleno", lleno, 1);
    chk("t4_ovf0", desborde, 0);
    load_word(21'h1F);
    chk("t4_ovf1", desborde, 1);
    chk("t4_cuenta2", cuenta, 32);
    pulse_borrar();
    chk("t4_clr_cuenta", cuenta, 0);
    chk("t4_clr_lleno", lleno, 0);
    chk("t4_clr_ovf", desborde, 0);

    // start on empty, then abort and rerun
    start();
    chk("t5_empty_valida", valida, 0);
    chk("t5_empty_ocupado", ocupado, 0);
    tick();
    chk("t5_empty_term", terminado, 0);
    for (int i = 0; i < 4; i++) load_word(wv[i]);
    listo_isa = 1'b1;
    start();
    tick();
    chk("t5_pc1", pc, 1);
    detener = 1'b1;
    tick();
    detener = 1'b0;
    chk("t5_abort_valida", valida, 0);
    chk("t5_abort_pc", pc, 0);
    chk("t5_abort_term", terminado, 0);
    tick();
    chk("t5_abort_term2", terminado, 0);
    start();
    for (int i = 0; i < 4; i++) begin
      chk("t5_rerun_pc", pc, i);
      chk("t5_rerun_instr", instruccion, wv[i]);
      tick();
    end
    chk("t5_rerun_term", terminado, 1);
    tick();

    // async reset mid-run
    start();
    tick();
    tick();
    chk("t6_pc2", pc, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valida", valida, 0);
    chk("t6_rst_cuenta", cuenta, 0);
    chk("t6_rst_ocupado", ocupado, 0);
    tick();
    rst_n = 1'b1;
    start();
    chk("t6_post_valida", valida, 0);
    tick();
    chk("t6_post_term", terminado, 0);
    chk("t6_post_ocupado", ocupado, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/emisor_instrucciones.md
Name: emisor_instrucciones

Overview:
- Producer side of the 21-bit instruction interface consumed by the ISA datapath (register file, ALU, RAM).
- Packs instruction fields supplied by the host into the 21-bit word and stores them in an internal program buffer.
- On command, issues the stored program in order to the datapath over a valid/ready handshake.
- Sits between the host/test controller and the datapath's instruccion input.

Parameters:
PROG_DEPTH, 32, number of program buffer entries
ADDR_W, 5, log2(PROG_DEPTH); width of pc
INSTR_W, 21, instruction word width (fixed by datapath format)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
carga  input  1  write-strobe; packs field inputs into next buffer slot
dl1  input  5  register-file read address 1 -> word[19:15]
dl2  input  5  register-file read address 2 -> word[14:10]
we_br  input  1  register-file write enable -> word[9]
alu_op  input  3  ALU operation -> word[8:6]
dir_ram  input  5  RAM address -> word[5:1]
we_ram  input  1  RAM write enable -> word[0]
borrar  input  1  clears program count (IDLE only)
iniciar  input  1  start issuing the program
detener  input  1  abort issuing
listo_isa  input  1  datapath ready to accept instruccion
instruccion  output  21  issued instruction word, registered
valida  output  1  instruccion is valid
pc  output  ADDR_W  index of the entry currently presented
cuenta  output  ADDR_W+1  number of stored instructions
lleno  output  1  cuenta == PROG_DEPTH
desborde  output  1  sticky: a carga was dropped because the buffer was full
ocupado  output  1  state == RUN
terminado  output  1  one-cycle pulse after the last instruction is accepted

Behaviour:
- Reset (async, rst_n=0): state IDLE; instruccion=0, valida=0, pc=0, cuenta=0, desborde=0, terminado=0, ocupado=0. Buffer contents are not reset; with cuenta=0 they are unreadable.
- Packing: word = {1'b0, dl1, dl2, we_br, alu_op, dir_ram, we_ram}. Bit 20 is always 0.
- States: IDLE, RUN, FIN.
- IDLE, loading:
  - carga and !lleno: mem[cuenta] <= word; cuenta++.
  - carga and lleno: write dropped; desborde <= 1 (sticky until reset or borrar).
- IDLE, borrar: cuenta <= 0; desborde <= 0.
- IDLE, priority: borrar > iniciar > carga when asserted in the same cycle.
- IDLE, iniciar:
  - cuenta == 0: ignored; stays IDLE, valida stays 0.
  - cuenta > 0: at the sampling edge, state <= RUN, pc <= 0, instruccion <= mem[0], valida <= 1. valida is visible the cycle after iniciar.
- RUN, handshake (transfer = valida & listo_isa at a rising edge):
  - Transfer and pc < cuenta-1: pc++; instruccion <= mem[pc+1]; valida stays 1. Back-to-back issue is 1 instruction/cycle while listo_isa=1.
  - Transfer and pc == cuenta-1: valida <= 0; terminado <= 1; state <= FIN.
  - No transfer: instruccion and pc held stable; valida stays 1. valida never drops without a transfer or an abort.
- RUN, detener: valida <= 0, pc <= 0, state <= IDLE, no terminado pulse. If a transfer coincides with detener, that transfer counts as accepted but the abort still wins.
- RUN, ignored inputs: carga, borrar, iniciar.
- FIN: one cycle; terminado <= 0; state <= IDLE. cuenta is retained so the program can be rerun with iniciar.
- ocupado = (state == RUN), registered.
- Reset asserted mid-RUN: valida drops to 0 immediately (asynchronous); all state is cleared as in the reset bullet.

Test Plan:
- Load 1 entry (dl1=1, dl2=2, we_br=1, alu_op=010, dir_ram=4, we_ram=1) -> cuenta=1; iniciar with listo_isa=1 -> next cycle instruccion=0x08A89 and valida=1 for exactly 1 cycle; terminado pulses the following cycle; back in IDLE after FIN.
- Load 3 distinct words, listo_isa=1 constant, iniciar -> valida high 3 consecutive cycles, pc 0,1,2, words in load order; terminado pulses once; ocupado high for 3 cycles.
- Backpressure: 3 words loaded, listo_isa=0 for 4 cycles after the first valida -> instruccion and pc=0 stable, valida=1 throughout; listo_isa=1 -> remaining words issue one per cycle.
- Overflow: 33 carga pulses -> cuenta=32, lleno=1 after the 32nd, desborde=1 after the 33rd; borrar -> cuenta=0, lleno=0, desborde=0.
- iniciar with cuenta=0 -> valida, ocupado and terminado stay 0. detener at pc=1 of a 4-word run -> valida=0 next cycle, pc=0, no terminado; rerun with iniciar issues all 4 words from pc=0.
- rst_n asserted low mid-run at pc=2 -> valida=0 and cuenta=0 immediately, without waiting for a clock edge; after release, iniciar is ignored (cuenta=0).
